// File: rtl/tx_arb_pkg.sv
// Shared types, default frame limit and counter widths for the two-port TX frame arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  localparam int unsigned MaxLenDefault = 1518;
  localparam int unsigned ByteCntW      = 11;
  localparam int unsigned FrameCntW     = 16;
  localparam int unsigned EventCntW     = 8;

  // Frame-granular round-robin: on a tie the port not served last wins.
  function automatic logic next_grant(logic [1:0] valid, logic last_served);
    return (valid == 2'b11) ? ~last_served : valid[1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tx_frame_arbiter.sv
// Two-requester byte-stream arbiter feeding one MAC: frame-level round-robin, zero-latency
// pass-through, oversize truncation with drain, and per-port / event statistics.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned MAX_LEN = MaxLenDefault
) (
  input  logic                 tx_mac_clk,
  input  logic                 rstn,
  input  logic [1:0]           req_valid,
  input  logic [15:0]          req_data,
  input  logic [1:0]           req_last,
  input  logic [1:0]           req_error,
  output logic [1:0]           req_ready,
  output logic                 tx_mac_valid,
  output logic [7:0]           tx_mac_data,
  output logic                 tx_mac_last,
  output logic                 tx_mac_error,
  input  logic                 tx_mac_ready,
  input  logic                 tx_collision,
  output logic                 grant,
  output logic                 busy,
  output logic [FrameCntW-1:0] frame_cnt_a,
  output logic [FrameCntW-1:0] frame_cnt_b,
  output logic [EventCntW-1:0] oversize_cnt,
  output logic [EventCntW-1:0] collision_cnt
);

  arb_state_e            state_q, state_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic                  grant_q, grant_d;
  logic                  last_served_q, last_served_d;
  logic [FrameCntW-1:0]  frame_cnt_a_q, frame_cnt_b_q;
  logic                  busy_q;
  logic                  frame_done;
  logic                  oversize_inc;

  logic                  sel_valid;
  logic [7:0]            sel_data;
  logic                  sel_last;
  logic                  sel_error;
  logic                  at_limit;
  logic                  force_trunc;

  assign sel_valid = req_valid[grant_q];
  assign sel_data  = grant_q ? req_data[15:8] : req_data[7:0];
  assign sel_last  = req_last[grant_q];
  assign sel_error = req_error[grant_q];

  // Beat MAX_LEN is being presented; cut the frame unless the requester ends it here anyway.
  assign at_limit    = (byte_cnt_q == ByteCntW'(MAX_LEN - 1));
  assign force_trunc = at_limit && !sel_last;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    req_ready     = 2'b00;
    tx_mac_valid  = 1'b0;
    tx_mac_data   = 8'h00;
    tx_mac_last   = 1'b0;
    tx_mac_error  = 1'b0;
    frame_done    = 1'b0;
    oversize_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          grant_d = next_grant(req_valid, last_served_q);
          state_d = StXfer;
        end
      end

      StXfer: begin
        tx_mac_valid       = sel_valid;
        tx_mac_data        = sel_data;
        tx_mac_last        = sel_last | force_trunc;
        tx_mac_error       = sel_error | force_trunc;
        req_ready[grant_q] = tx_mac_ready;
        if (sel_valid && tx_mac_ready) begin
          if (force_trunc) begin
            byte_cnt_d = '0;
            state_d    = StDrain;
          end else if (sel_last) begin
            byte_cnt_d    = '0;
            last_served_d = grant_q;
            frame_done    = 1'b1;
            state_d       = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
          end
        end
      end

      StDrain: begin
        // Swallow the tail of a truncated frame; the MAC never sees it.
        req_ready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_served_d = grant_q;
          oversize_inc  = 1'b1;
          state_d       = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge tx_mac_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      byte_cnt_q    <= '0;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      busy_q        <= (state_d != StIdle);
    end
  end

  always_ff @(posedge tx_mac_clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_a_q <= '0;
      frame_cnt_b_q <= '0;
    end else if (frame_done) begin
      if (grant_q) begin
        frame_cnt_b_q <= frame_cnt_b_q + FrameCntW'(1);
      end else begin
        frame_cnt_a_q <= frame_cnt_a_q + FrameCntW'(1);
      end
    end
  end

  sat_counter #(
    .Width(EventCntW)
  ) u_oversize_cnt (
    .clk   (tx_mac_clk),
    .rst_n (rstn),
    .inc   (oversize_inc),
    .count (oversize_cnt)
  );

  sat_counter #(
    .Width(EventCntW)
  ) u_collision_cnt (
    .clk   (tx_mac_clk),
    .rst_n (rstn),
    .inc   (tx_collision),
    .count (collision_cnt)
  );

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_cnt_a = frame_cnt_a_q;
  assign frame_cnt_b = frame_cnt_b_q;

endmodule
